// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the pair decoder and the display
// driver's encoder.
//   SEG_*        : 7-bit active-high segment patterns, bit order g..a
//   CODE_BLANK   : code recovered from an all-off phase
//   CODE_INVALID : code recovered from any unrecognised pattern
//   dec_state_t  : decoder FSM states
//   seg7_encode  : code -> pattern, the inverse of the decode map
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [3:0] CODE_BLANK   = 4'hF;
   localparam logic [3:0] CODE_INVALID = 4'hE;

   typedef enum logic {
      WAIT_TENS = 1'b0,
      WAIT_ONES = 1'b1
   } dec_state_t;

   // Codes with no pattern (A..E) encode as blank so the display goes dark
   // rather than showing garbage.
   function automatic logic [6:0] seg7_encode(input logic [3:0] code);
      logic [6:0] pat;
      case (code)
         4'd0:    pat = SEG_0;
         4'd1:    pat = SEG_1;
         4'd2:    pat = SEG_2;
         4'd3:    pat = SEG_3;
         4'd4:    pat = SEG_4;
         4'd5:    pat = SEG_5;
         4'd6:    pat = SEG_6;
         4'd7:    pat = SEG_7;
         4'd8:    pat = SEG_8;
         4'd9:    pat = SEG_9;
         default: pat = SEG_BLANK;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/seg7_pair_decoder_if.sv
// Display-bus monitor interface.
//   seg_in      : multiplexed display bus {select, segments g..a}
//   tens, ones  : last published digit pair
//   frame_valid : one-cycle pulse, new pair published
//   changed     : one-cycle pulse with frame_valid when the pair differs
//   seg_err     : one-cycle pulse on an accepted illegal pattern
// master = side driving the display bus, slave = the decoder.
interface seg7_pair_decoder_if;

   logic [7:0] seg_in;
   logic [3:0] tens;
   logic [3:0] ones;
   logic       frame_valid;
   logic       changed;
   logic       seg_err;

   modport master (
      output seg_in,
      input  tens,
      input  ones,
      input  frame_valid,
      input  changed,
      input  seg_err
   );

   modport slave (
      input  seg_in,
      output tens,
      output ones,
      output frame_valid,
      output changed,
      output seg_err
   );

endinterface

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern to 4-bit code.
//   seg_i  : segments g..a, active-high
//   code_o : 0..9, CODE_BLANK for all-off, CODE_INVALID otherwise
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] code_o
);

   always_comb begin
      code_o = CODE_INVALID;
      case (seg_i)
         SEG_0:     code_o = 4'd0;
         SEG_1:     code_o = 4'd1;
         SEG_2:     code_o = 4'd2;
         SEG_3:     code_o = 4'd3;
         SEG_4:     code_o = 4'd4;
         SEG_5:     code_o = 4'd5;
         SEG_6:     code_o = 4'd6;
         SEG_7:     code_o = 4'd7;
         SEG_8:     code_o = 4'd8;
         SEG_9:     code_o = 4'd9;
         SEG_BLANK: code_o = CODE_BLANK;
         default:   code_o = CODE_INVALID;
      endcase
   end

endmodule

// File: rtl/seg7_pair_decoder.sv
// Recovers the two digits shown on a time-multiplexed seven-segment bus.
// A phase is accepted once the bus has held the same value for
// STABLE_CYCLES consecutive samples; a tens phase followed by a ones phase
// publishes a pair.
//   clk   : clock, same domain as the display driver
//   reset : asynchronous, active-high
//   bus   : slave side of seg7_pair_decoder_if
//   STABLE_CYCLES : identical samples needed for acceptance, 1..15
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   WAIT_TENS | waiting for an accepted select=1 phase; ones phases ignored
//   WAIT_ONES | tens held in tens_hold_q; a ones phase publishes the pair,
//             | another tens phase replaces tens_hold_q
module seg7_pair_decoder
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 2
) (
   input logic          clk,
   input logic          reset,
   seg7_pair_decoder_if.slave bus
);

   localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

   logic [7:0]       seg_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             same;
   logic             accept;
   logic [3:0]       code;

   dec_state_t       state_q;
   logic [3:0]       tens_hold_q;
   logic [3:0]       tens_q;
   logic [3:0]       ones_q;
   logic             frame_valid_q;
   logic             changed_q;
   logic             seg_err_q;

   seg7_decode u_decode (
      .seg_i  (bus.seg_in[6:0]),
      .code_o (code)
   );

   // Acceptance fires on the edge the counter arrives at CNT_MAX. A bus
   // change always restarts a phase, so with STABLE_CYCLES=1 a change is
   // an acceptance even though the counter already sits at CNT_MAX.
   always_comb begin
      same = (bus.seg_in == seg_q);
      if (!same) begin
         cnt_d = CNT_W'(1);
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
      accept = (cnt_d == CNT_MAX) && !(same && (cnt_q == CNT_MAX));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_q         <= 8'h00;
         cnt_q         <= '0;
         state_q       <= WAIT_TENS;
         tens_hold_q   <= CODE_BLANK;
         tens_q        <= CODE_BLANK;
         ones_q        <= CODE_BLANK;
         frame_valid_q <= 1'b0;
         changed_q     <= 1'b0;
         seg_err_q     <= 1'b0;
      end else begin
         seg_q         <= bus.seg_in;
         cnt_q         <= cnt_d;
         frame_valid_q <= 1'b0;
         changed_q     <= 1'b0;
         // Flagged even for phases the FSM ignores.
         seg_err_q     <= accept && (code == CODE_INVALID);
         if (accept) begin
            case (state_q)
               WAIT_TENS: begin
                  if (bus.seg_in[7]) begin
                     tens_hold_q <= code;
                     state_q     <= WAIT_ONES;
                  end
               end
               WAIT_ONES: begin
                  if (bus.seg_in[7]) begin
                     tens_hold_q <= code;
                  end else begin
                     tens_q        <= tens_hold_q;
                     ones_q        <= code;
                     frame_valid_q <= 1'b1;
                     changed_q     <= ({tens_hold_q, code} != {tens_q, ones_q});
                     state_q       <= WAIT_TENS;
                  end
               end
               default: state_q <= WAIT_TENS;
            endcase
         end
      end
   end

   assign bus.tens        = tens_q;
   assign bus.ones        = ones_q;
   assign bus.frame_valid = frame_valid_q;
   assign bus.changed     = changed_q;
   assign bus.seg_err     = seg_err_q;

endmodule

// File: tb/tb_seg7_pair_decoder.sv
module tb_seg7_pair_decoder;
   import seg7_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   seg7_pair_decoder_if bus ();

   seg7_pair_decoder #(.STABLE_CYCLES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [3:0] t;
      logic [3:0] o;
      logic       ch;
   } frame_t;

   frame_t     exp_q[$];
   bit         err_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   logic [3:0] prev_t   = 4'hF;
   logic [3:0] prev_o   = 4'hF;
   bit         mon_en   = 1'b0;

   // Push the expected published pair; changed is derived from the last
   // pair this model expects the decoder to have published.
   task automatic exp_frame(input logic [3:0] t, input logic [3:0] o);
      frame_t f;
      f.t  = t;
      f.o  = o;
      f.ch = ({t, o} != {prev_t, prev_o});
      exp_q.push_back(f);
      prev_t = t;
      prev_o = o;
   endtask

   task automatic hold(input logic [7:0] v, input int n);
      bus.seg_in = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard: every pulse is matched against the queues.
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.frame_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_frame: got tens=%h ones=%h, required no frame", bus.tens, bus.ones);
            end else begin
               frame_t f;
               f = exp_q.pop_front();
               if (bus.tens !== f.t || bus.ones !== f.o || bus.changed !== f.ch) begin
                  n_fail++;
                  $display("FAIL frame: got %h/%h changed=%b, required %h/%h changed=%b",
                           bus.tens, bus.ones, bus.changed, f.t, f.o, f.ch);
               end
            end
         end
         if (bus.changed === 1'b1 && bus.frame_valid !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL changed_alone: changed=1 with frame_valid=%b, required frame_valid=1", bus.frame_valid);
         end
         if (bus.seg_err === 1'b1) begin
            n_checks++;
            if (err_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_err: seg_err=1, required 0");
            end else begin
               bit w;
               w = err_q.pop_front();
               if (bus.frame_valid !== w) begin
                  n_fail++;
                  $display("FAIL err_frame_align: frame_valid=%b with seg_err, required %b", bus.frame_valid, w);
               end
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      bus.seg_in = 8'h00;
      idle(3);
      n_checks++;
      if ({bus.tens, bus.ones, bus.frame_valid, bus.changed, bus.seg_err} !== {4'hF, 4'hF, 3'b000}) begin
         n_fail++;
         $display("FAIL reset_values: got %h/%h fv=%b ch=%b err=%b, required F/F 0 0 0",
                  bus.tens, bus.ones, bus.frame_valid, bus.changed, bus.seg_err);
      end
      reset = 1'b0;
      mon_en = 1'b1;
      // all-zero bus is a blank ones phase: ignored, no error
      idle(4);
      n_checks++;
      if (exp_q.size() != 0 || err_q.size() != 0) begin
         n_fail++;
         $display("FAIL reset_drain: pending frames=%0d errs=%0d, required 0", exp_q.size(), err_q.size());
      end
   endtask

   task automatic test_basic_frame();
      exp_frame(4'd1, 4'd2);
      hold(8'h86, 2);
      hold(8'h5B, 2);
      idle(4);
      n_checks++;
      if (exp_q.size() != 0 || bus.tens !== 4'd1 || bus.ones !== 4'd2) begin
         n_fail++;
         $display("FAIL basic_frame: pending=%0d tens=%h ones=%h, required 0 1 2", exp_q.size(), bus.tens, bus.ones);
      end
   endtask

   task automatic test_repeat_frame();
      exp_frame(4'd1, 4'd2);
      hold(8'h86, 2);
      hold(8'h5B, 2);
      idle(3);
      n_checks++;
      if (exp_q.size() != 0 || err_q.size() != 0) begin
         n_fail++;
         $display("FAIL repeat_frame: pending frames=%0d errs=%0d, required 0", exp_q.size(), err_q.size());
      end
   endtask

   task automatic test_invalid_ones();
      exp_frame(4'd1, CODE_INVALID);
      err_q.push_back(1'b1);
      hold(8'h86, 2);
      hold(8'h12, 2);
      idle(3);
      n_checks++;
      if (exp_q.size() != 0 || err_q.size() != 0 || bus.ones !== 4'hE) begin
         n_fail++;
         $display("FAIL invalid_ones: pending=%0d/%0d ones=%h, required 0/0 E", exp_q.size(), err_q.size(), bus.ones);
      end
   endtask

   task automatic test_glitch();
      exp_frame(4'd9, 4'd2);
      hold(8'hFF, 1);
      hold(8'hEF, 2);
      hold(8'h5B, 2);
      idle(3);
      n_checks++;
      if (exp_q.size() != 0 || bus.tens !== 4'd9) begin
         n_fail++;
         $display("FAIL glitch: pending=%0d tens=%h, required 0 9", exp_q.size(), bus.tens);
      end
   endtask

   task automatic test_ignored_err();
      err_q.push_back(1'b0);
      hold(8'h12, 2);
      idle(3);
      n_checks++;
      if (err_q.size() != 0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL ignored_err: pending errs=%0d frames=%0d, required 0", err_q.size(), exp_q.size());
      end
   endtask

   task automatic test_overwrite();
      exp_frame(4'd3, 4'd0);
      hold(8'h06, 2);   // lone ones phase in WAIT_TENS
      hold(8'h86, 2);
      hold(8'hCF, 2);   // second tens phase replaces the first
      hold(8'h3F, 2);
      idle(3);
      n_checks++;
      if (exp_q.size() != 0 || bus.tens !== 4'd3 || bus.ones !== 4'd0) begin
         n_fail++;
         $display("FAIL overwrite: pending=%0d tens=%h ones=%h, required 0 3 0", exp_q.size(), bus.tens, bus.ones);
      end
   endtask

   task automatic test_back_to_back();
      exp_frame(4'd1, 4'd2);
      exp_frame(4'd5, 4'd6);
      hold(8'h86, 6);   // long hold accepted once
      hold(8'h5B, 2);
      hold(8'hED, 2);
      hold(8'h7D, 5);
      idle(2);
      n_checks++;
      if (exp_q.size() != 0 || bus.tens !== 4'd5 || bus.ones !== 4'd6) begin
         n_fail++;
         $display("FAIL back_to_back: pending=%0d tens=%h ones=%h, required 0 5 6", exp_q.size(), bus.tens, bus.ones);
      end
   endtask

   task automatic test_reset_mid_frame();
      hold(8'h86, 2);   // now in WAIT_ONES
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if ({bus.tens, bus.ones, bus.frame_valid, bus.changed, bus.seg_err} !== {4'hF, 4'hF, 3'b000}) begin
         n_fail++;
         $display("FAIL async_reset: got %h/%h fv=%b ch=%b err=%b, required F/F 0 0 0",
                  bus.tens, bus.ones, bus.frame_valid, bus.changed, bus.seg_err);
      end
      @(negedge clk);
      reset = 1'b0;
      prev_t = 4'hF;
      prev_o = 4'hF;
      exp_frame(CODE_BLANK, CODE_BLANK);
      hold(8'h80, 2);
      hold(8'h00, 2);
      idle(3);
      n_checks++;
      if (exp_q.size() != 0 || err_q.size() != 0) begin
         n_fail++;
         $display("FAIL blank_after_reset: pending frames=%0d errs=%0d, required 0", exp_q.size(), err_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_repeat_frame();
      test_invalid_ones();
      test_glitch();
      test_ignored_err();
      test_overwrite();
      test_back_to_back();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/seg7_pair_decoder.md
# seg7_pair_decoder

Receive-side counterpart of the dual seven-segment display driver: watches the time-multiplexed 8-bit display bus ({digit select, segments g..a}) and recovers the two displayed digits as 4-bit codes. It sits in the bench/top as a self-checking monitor on `uo_out`, and is reusable on-chip wherever a multiplexed display stream must be read back. Each phase is accepted only after it holds stable for a programmable number of cycles. Outputs are a registered digit pair, a frame strobe, a change strobe and an error strobe.

## Interface
- STABLE_CYCLES, default 2: consecutive identical samples required to accept a phase; legal range 1..15.
- clk  in  1  clock, same domain as the display driver.
- reset  in  1  asynchronous, active-high.
- seg_in  in  8  display bus; bit 7 = select (1 = tens, 0 = ones); bits 6:0 = segments g..a, active-high.
- tens  out  4  last accepted tens code.
- ones  out  4  last accepted ones code.
- frame_valid  out  1  one-cycle pulse: new tens/ones pair published.
- changed  out  1  one-cycle pulse coincident with frame_valid when the pair differs from the previous published pair.
- seg_err  out  1  one-cycle pulse when an accepted phase carries an illegal pattern.

## Operation
- Code map, segments 6:0 -> code:
  - 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7, 0x7F->8, 0x6F->9.
  - 0x00->4'hF (BLANK).
  - Any other pattern -> 4'hE (INVALID).
- Sample register `seg_q` captures seg_in every edge. Stability counter `cnt`, width $clog2(STABLE_CYCLES+1):
  - Resets to 1 when seg_in differs from seg_q.
  - Otherwise increments, saturating at STABLE_CYCLES.
  - A phase is accepted on the edge where cnt reaches STABLE_CYCLES (a 0->STABLE transition, not while saturated). A held pattern is accepted exactly once.
- FSM states:
  - WAIT_TENS (reset state): accepted select=1 phase -> store code in tens_hold, go to WAIT_ONES. Accepted select=0 phase is ignored; stay.
  - WAIT_ONES:
    - Accepted select=0 phase -> publish: tens<=tens_hold, ones<=code, frame_valid=1, changed=({tens_hold,code}!={tens,ones}); go to WAIT_TENS.
    - Accepted select=1 phase -> overwrite tens_hold and stay (a glitched ones phase is skipped).
- seg_err pulses on any accepted phase whose code is INVALID, including ignored phases. Invalid codes are still stored and published.
- Select or segment change before acceptance: that phase is discarded silently, with no error.
- A frame consisting of BLANK/BLANK is a normal frame (display off).

## Timing
- Reset values: tens=4'hF, ones=4'hF, frame_valid=0, changed=0, seg_err=0, seg_q=0, cnt=0, state=WAIT_TENS. tens_hold=4'hF.
- Reset mid-frame: the partial frame is discarded; the first frame after reset is taken against the reset pair 4'hF/4'hF for `changed`.
- Latency: seg_in first presented before edge k and held -> accepted at edge k+STABLE_CYCLES-1. Output regs are visible after that edge.
- All outputs are registered; there is no combinational path from seg_in.
- frame_valid and changed fall on the next edge, with no back-to-back frame_valid possible when STABLE_CYCLES>=1 (a frame needs two acceptances).
- With STABLE_CYCLES=1, each edge where seg_in changes is an acceptance. A 2-cycle-per-phase driver yields one frame per 4 cycles.

## Structure
- Package `seg7_pkg`:
  - The 7-bit pattern constants for 0-9 and blank.
  - BLANK=4'hF and INVALID=4'hE.
  - State enum `dec_state_t {WAIT_TENS, WAIT_ONES}`.
- The display driver's encoder shares the same constants.
- Sub-module `seg7_decode`: combinational 7-bit pattern -> 4-bit code. The FSM, counter and output registers stay in the top module.

## Test plan
- Driver-style stream, STABLE_CYCLES=2: tens=0x06 (sel=1) for 2 cycles, then ones=0x5B (sel=0) for 2 cycles -> frame_valid once, tens=1, ones=2, changed=1.
- Repeat the identical frame -> frame_valid pulses; changed=0; seg_err=0.
- Ones phase 0x12 held 2 cycles -> ones=4'hE published; seg_err pulse at acceptance; frame_valid at the same edge.
- 1-cycle glitch: tens phase 0x7F held 1 cycle, then 0x6F held 2 -> tens=9 (not 8), with no error.
- Sequence sel=1 accepted, sel=1 accepted again (0x4F), then sel=0 0x3F -> tens=3, ones=0; a leading lone sel=0 phase is ignored.
- Assert reset in WAIT_ONES: outputs return to F/F/0/0/0 asynchronously. The next full frame 0x00/0x00 -> frame_valid=1, changed=0.
